multicycle_ctrl: RTL

//  Multi-cycle MIPS control FSM; next-generation successor to the single-cycle opcode decoder.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/multicycle_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath mux codes and the bundled control-output struct.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_WB_ALU = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_out_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the last allowed
// wait cycle (count == TIMEOUT_CYC-1).
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (inc && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, timeout and illegal-opcode traps.
// Optional feature: define CTRL_JAL_EN to decode opcode 0x03 as jal (otherwise it traps).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            beq,
  output logic            bne,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            retire,
  output logic            illegal,
  output logic            bus_err
);

  state_t          state_reg, state_next;
  logic [OP_W-1:0] op_reg;
  logic            illegal_reg, bus_err_reg;
  logic            set_illegal, set_bus_err;
  logic            mem_wait, timer_clear, expired;
  ctrl_out_t       o, outs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      op_reg      <= '0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) op_reg <= opcode;
      if (set_illegal) illegal_reg <= 1'b1;
      if (set_bus_err) bus_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    o           = '0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    mem_wait    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        o.mem_read = 1'b1;
        if (mem_ready) begin
          o.ir_write  = 1'b1;
          o.alu_src_b = ALUSRCB_FOUR;
          o.alu_op    = ALUOP_ADD;
          o.pc_write  = 1'b1;
          o.pc_source = PCSRC_ALU;
          state_next  = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        o.alu_src_b = ALUSRCB_IMM_SH;
        o.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_W'(OP_RTYPE):            state_next = S_EXEC_R;
          OP_W'(OP_LW), OP_W'(OP_SW): state_next = S_ADDR;
          OP_W'(OP_BEQ), OP_W'(OP_BNE): state_next = S_BRANCH;
          OP_W'(OP_J):                state_next = S_JUMP;
          OP_W'(OP_ADDI):             state_next = S_EXEC_I;
`ifdef CTRL_JAL_EN
          OP_W'(OP_JAL):              state_next = S_JAL;
`else
          OP_W'(OP_JAL): begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
`endif
          default: begin
            state_next  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_ADDR: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUSRCB_IMM;
        o.alu_op    = ALUOP_ADD;
        state_next  = (op_reg == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        o.iord     = 1'b1;
        o.mem_read = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
        else           mem_wait   = 1'b1;
      end
      S_MEM_WR: begin
        o.iord      = 1'b1;
        o.mem_write = 1'b1;
        if (mem_ready) begin
          o.retire   = 1'b1;
          state_next = S_FETCH;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_WB_MEM: begin
        o.reg_dst    = REGDST_RT;
        o.mem_to_reg = MEMTOREG_MDR;
        o.reg_write  = 1'b1;
        o.retire     = 1'b1;
        state_next   = S_FETCH;
      end
      S_EXEC_R: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUSRCB_RT;
        o.alu_op    = ALUOP_FUNCT;
        state_next  = S_WB_ALU;
      end
      S_EXEC_I: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUSRCB_IMM;
        o.alu_op    = ALUOP_ADD;
        state_next  = S_WB_ALU;
      end
      S_WB_ALU: begin
        o.reg_dst    = (op_reg == OP_W'(OP_RTYPE)) ? REGDST_RD : REGDST_RT;
        o.mem_to_reg = MEMTOREG_ALU;
        o.reg_write  = 1'b1;
        o.retire     = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = ALUSRCB_RT;
        o.alu_op    = ALUOP_SUB;
        o.pc_source = PCSRC_ALUOUT;
        o.beq       = (op_reg == OP_W'(OP_BEQ));
        o.bne       = (op_reg != OP_W'(OP_BEQ));
        o.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        o.pc_source = PCSRC_JUMP;
        o.pc_write  = 1'b1;
        o.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so it is the link value for r31.
        o.pc_source  = PCSRC_JUMP;
        o.pc_write   = 1'b1;
        o.reg_dst    = REGDST_R31;
        o.mem_to_reg = MEMTOREG_PC;
        o.reg_write  = 1'b1;
        o.retire     = 1'b1;
        state_next   = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
    // A late mem_ready on the final allowed cycle wins over the timeout.
    if (mem_wait && expired) begin
      state_next  = S_TRAP;
      set_bus_err = 1'b1;
    end
  end

  assign timer_clear = !mem_wait;

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .inc    (mem_wait),
    .expired(expired)
  );

  assign outs     = rst ? '0 : o;
  assign PCWrite  = outs.pc_write;
  assign beq      = outs.beq;
  assign bne      = outs.bne;
  assign IorD     = outs.iord;
  assign MemRead  = outs.mem_read;
  assign MemWrite = outs.mem_write;
  assign IRWrite  = outs.ir_write;
  assign RegDst   = outs.reg_dst;
  assign MemtoReg = outs.mem_to_reg;
  assign RegWrite = outs.reg_write;
  assign ALUSrcA  = outs.alu_src_a;
  assign ALUSrcB  = outs.alu_src_b;
  assign ALUOp    = outs.alu_op;
  assign PCSource = outs.pc_source;
  assign retire   = outs.retire;
  assign illegal  = illegal_reg & ~rst;
  assign bus_err  = bus_err_reg & ~rst;

endmodule
